mips32_imem_loader: RTL
=======================

Name: mips32_imem_loader

Overview:
Parametrised boot loader for the mips32 core. It accepts a program as a valid/ready word stream and writes it into instruction memory starting at BASE_ADDR. It keeps a running checksum of the words written, then raises cpu_en so the core starts fetching. It replaces direct back-door pokes of the instruction memory and hard-wired enables, with length checking, abort and error reporting.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 10, instruction memory word-address width
DEPTH, 1024, number of instruction memory words; must be <= 2^ADDR_W
BASE_ADDR, 0, first word address written by a load

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a load; sampled only in IDLE
load_len  in  ADDR_W+1  number of words to load; sampled with start
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  loader accepts a word this cycle
halt  in  1  abort a load, or stop a running core; return to IDLE
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  ADDR_W  instruction memory write address
mem_wdata  out  DATA_W  instruction memory write data
cpu_en  out  1  core run enable (drives mips32 en)
done  out  1  load completed successfully; high while RUN
err  out  1  bad load_len; high while ERR
checksum  out  DATA_W  sum mod 2^DATA_W of all words written by the current load

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - s_ready, mem_we, cpu_en, done and err are 0.
  - mem_addr=BASE_ADDR; mem_wdata=0; checksum=0.
  - Reset mid-load discards any pending write; no write strobe appears after reset deasserts.
- Handshake: a word transfers on a rising edge where s_valid&&s_ready. s_ready is a registered state decode, high only in LOAD, with no combinational path from s_valid.
- States: IDLE, LOAD, RUN, ERR.
- IDLE:
  - start with 1 <= load_len and BASE_ADDR+load_len <= DEPTH → LOAD.
    - Word counter = load_len; address pointer = BASE_ADDR; checksum cleared to 0.
  - start with any other load_len → ERR; err=1 the next cycle.
  - halt in IDLE has no effect.
- LOAD:
  - Each transfer at edge t produces, for exactly one cycle after edge t+1:
    - mem_we=1, mem_addr=pointer, mem_wdata=s_data.
    - Latency is 1 cycle.
  - Pointer increments by 1. Counter decrements by 1. checksum += s_data, updated at the same edge the write is registered.
  - Back-to-back transfers every cycle are supported (one write per cycle, no bubbles).
  - Transfer of the final word → RUN at the next edge. s_ready drops in the cycle after the final transfer; no further words are accepted.
  - halt (in the same cycle as a transfer, or in any cycle) → IDLE.
    - A write already registered still completes.
    - A word transferring in the halt cycle is written.
    - done stays 0; checksum holds its value.
  - start is ignored in LOAD.
- RUN:
  - cpu_en=1 and done=1, both registered. The first cycle of cpu_en follows the final mem_we cycle, so the core never fetches a word not yet written.
  - start is ignored.
  - halt → IDLE; cpu_en and done are 0 from the next cycle. checksum holds until the next accepted start.
- ERR:
  - err=1, s_ready=0, cpu_en=0.
  - Only halt leaves ERR, going to IDLE with err cleared.
- Simultaneous start and halt in IDLE: start wins.
- Address arithmetic is unsigned ADDR_W bits. The length check at start guarantees no wrap past DEPTH-1. load_len=DEPTH with BASE_ADDR=0 is legal and fills memory exactly.
- Checksum addition wraps modulo 2^DATA_W; overflow is not flagged.

Decomposition:
- Package mips32_pkg gains:
  - state encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2, ST_ERR=2'd3.
  - WORD_W=32.
- Sub-module mips32_imem_wr_stage holds the registered write port (mem_we/mem_addr/mem_wdata) and the checksum accumulator. Control FSM and counters stay in the top.

Test Plan:
- Basic load: BASE_ADDR=0; start with load_len=4; stream 0x03E0A800, 0x07E0A800, 0x0BE0A800, 0x0FE0A800 back-to-back.
  - Required: four consecutive mem_we cycles at addresses 0..3, each one cycle after its transfer.
  - checksum=0x2782A000; cpu_en rises the cycle after the last mem_we; done=1.
- Throttled source: same 4 words with s_valid low on alternate cycles → identical addresses, data and checksum; writes occur only after transfers.
- Bad length:
  - start with load_len=0 → err=1, s_ready stays 0, no mem_we.
  - halt → err=0, state IDLE.
  - Repeat with BASE_ADDR=1020, load_len=5 (DEPTH=1024) → err=1.
- Abort: load_len=4; halt asserted together with the 2nd transfer → exactly 2 writes (addr 0,1), cpu_en never rises, done=0, checksum=0x0BC15000.
- Reset mid-load: rst_n low between the 2nd and 3rd transfers, then high → all outputs 0 immediately, no mem_we afterwards, a new start with load_len=1 loads address BASE_ADDR.
- Run/stop: after a successful load, pulse start while in RUN → ignored (cpu_en stays 1). halt → cpu_en=0 next cycle; a new start with load_len=2 reloads and clears checksum.

Source files
------------

// File: rtl/mips32_pkg.sv
// mips32 shared definitions: word width and loader state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package mips32_pkg;

    // Native instruction word width of the mips32 core.
    localparam int WORD_W = 32;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/mips32_imem_wr_stage.sv
// Registered instruction-memory write port plus running checksum of written words.
// Latency: one cycle from wr_en at an edge to mem_we/mem_addr/mem_wdata valid.
// Backpressure: none; accepts one write per cycle, memory is assumed always writable.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_en/wr_addr/wr_data  word accepted this cycle and its target address
//   sum_clr             clear checksum (new load accepted)
//   mem_we/mem_addr/mem_wdata  registered write strobe/address/data to memory
//   checksum            sum mod 2^DATA_W of words written since last sum_clr
module mips32_imem_wr_stage
    import mips32_pkg::*;
#(
    parameter int DATA_W    = WORD_W,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              sum_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    // Strobe is a pure one-cycle pulse per accepted word; address/data
    // hold their last value between writes to keep the memory bus quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE_A;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

    // Checksum advances on the same edge the write is registered, so it
    // always reflects exactly the words whose strobe has been issued.
    // Wraps silently modulo 2^DATA_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (sum_clr) begin
            checksum <= '0;
        end else if (wr_en) begin
            checksum <= checksum + wr_data;
        end
    end

endmodule

// File: rtl/mips32_imem_loader.sv
// Boot loader: streams a program into instruction memory at BASE_ADDR, then enables the core.
// Latency: write strobe one cycle after each transfer; cpu_en rises the cycle after the last write.
// Backpressure: s_ready is a registered decode of LOAD, independent of s_valid; low in all other states.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, load_len            begin a load of load_len words (sampled in IDLE only)
//   s_valid, s_data, s_ready   program word stream (valid/ready)
//   halt                       abort a load / stop a running core / clear an error
//   mem_we, mem_addr, mem_wdata  instruction memory write port
//   cpu_en, done, err          core enable, load-complete flag, bad-length flag
//   checksum                   running sum of words written by the current load
module mips32_imem_loader
    import mips32_pkg::*;
#(
    parameter int DATA_W    = WORD_W,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              halt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_en,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    // Two spare bits so BASE_ADDR + load_len cannot overflow the check.
    localparam int                LCHK_W = ADDR_W + 2;
    localparam logic [LCHK_W-1:0] BASE_L = LCHK_W'(BASE_ADDR);
    localparam logic [LCHK_W-1:0] DEPTH_L = LCHK_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    state_t             state;
    state_t             next_state;
    logic [ADDR_W:0]    cnt;
    logic [ADDR_W-1:0]  ptr;
    logic [LCHK_W-1:0]  len_end;
    logic               len_ok;
    logic               xfer;
    logic               last_xfer;
    logic               ld_accept;

    // Length is legal when non-zero and the load stays inside memory;
    // this also guarantees the pointer never wraps during the load.
    assign len_end   = BASE_L + LCHK_W'(load_len);
    assign len_ok    = (load_len != '0) && (len_end <= DEPTH_L);

    // s_ready is high exactly while in LOAD, so xfer implies LOAD.
    assign xfer      = s_valid && s_ready;
    assign last_xfer = xfer && (cnt == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                // start takes priority over a simultaneous halt here.
                if (start) begin
                    if (len_ok) begin
                        next_state = ST_LOAD;
                        ld_accept  = 1'b1;
                    end else begin
                        next_state = ST_ERR;
                    end
                end
            end
            ST_LOAD: begin
                // A word transferring alongside halt is still written by
                // the write stage; only the state returns to IDLE.
                if (halt) begin
                    next_state = ST_IDLE;
                end else if (last_xfer) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (halt) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Remaining-word counter and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ptr <= BASE_A;
        end else if (ld_accept) begin
            cnt <= load_len;
            ptr <= BASE_A;
        end else if (xfer) begin
            cnt <= cnt - CNT_ONE;
            ptr <= ptr + ADDR_W'(1);
        end
    end

    // Registered status outputs. cpu_en/done need the state to already be
    // RUN, which delays their first cycle until after the final write strobe
    // (that strobe is issued on the same edge that enters RUN). Qualifying
    // with next_state drops them on the very edge that samples halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready <= 1'b0;
            cpu_en  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            s_ready <= (next_state == ST_LOAD);
            cpu_en  <= (state == ST_RUN) && (next_state == ST_RUN);
            done    <= (state == ST_RUN) && (next_state == ST_RUN);
            err     <= (next_state == ST_ERR);
        end
    end

    mips32_imem_wr_stage #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_wr_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (xfer),
        .wr_addr   (ptr),
        .wr_data   (s_data),
        .sum_clr   (ld_accept),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .checksum  (checksum)
    );

endmodule
